// File: rtl/clock_pkg.sv
// Shared definitions for the seg_clock time-setting path.
// Holds the edit FSM state encoding, time-field limits and the
// seconds-of-day arithmetic constants.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_H  = 3'd1,
    ST_SET_M  = 3'd2,
    ST_SET_S  = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  localparam int unsigned HOUR_MAX     = 23;
  localparam int unsigned MIN_MAX      = 59;
  localparam int unsigned SEC_PER_HOUR = 3600;
  localparam int unsigned SEC_PER_MIN  = 60;
  localparam int unsigned MAX_DAY      = 86400;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned DAY_W  = $clog2(MAX_DAY);

endpackage

// File: rtl/field_wrap_cnt.sv
// Wrapping up/down counter for one time field (hour, minute or second).
// Ports:
//   clk, rst   clock, synchronous active-high reset (value -> 0)
//   load       load load_val (highest priority after reset)
//   load_val   value to load
//   inc, dec   step +1 / -1 with wrap at 0..MAX; both together = hold
//   val        current field value
module field_wrap_cnt #(
  parameter  int unsigned MAX = 59,
  localparam int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] val
);

  logic [W-1:0] val_q, val_d;

  // Next value: load, else single-direction step with wrap.
  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = load_val;
    end else if (inc && !dec) begin
      val_d = (val_q == W'(MAX)) ? '0 : val_q + W'(1);
    end else if (dec && !inc) begin
      val_d = (val_q == '0) ? W'(MAX) : val_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

  assign val = val_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: walks hour/minute/second edit modes from
// key pulses, loads the new seconds-of-day into the counter block and
// drives per-field blink enables for the display.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   tick_1s                     one pulse per second (edit timeout base)
//   key_mode, key_inc, key_dec  debounced one-cycle key pulses
//   cur_hour/min/sec            live time from the counter
//   disp_hour/min/sec           time to display (live or edited)
//   blink_mask                  {hour,min,sec}, 1 = blank field now
//   load_en, load_day           one-cycle load of new seconds-of-day
//   setting                     high while editing or committing
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned BLINK_CYC = 25_000_000,
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1s,
  input  logic              key_mode,
  input  logic              key_inc,
  input  logic              key_dec,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [MIN_W-1:0]  cur_sec,
  output logic [HOUR_W-1:0] disp_hour,
  output logic [MIN_W-1:0]  disp_min,
  output logic [MIN_W-1:0]  disp_sec,
  output logic [2:0]        blink_mask,
  output logic              load_en,
  output logic [DAY_W-1:0]  load_day,
  output logic              setting
);

  localparam int unsigned BLINK_W = $clog2(BLINK_CYC);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_S + 1);

  state_e              state_q, state_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                load_en_q, load_en_d;
  logic [DAY_W-1:0]    load_day_q, load_day_d;
  logic                blink_rst;

  logic [HOUR_W-1:0]   edit_h;
  logic [MIN_W-1:0]    edit_m, edit_s;
  logic                capture;
  logic                sel_h, sel_m, sel_s, in_set;

  assign sel_h   = (state_q == ST_SET_H);
  assign sel_m   = (state_q == ST_SET_M);
  assign sel_s   = (state_q == ST_SET_S);
  assign in_set  = sel_h | sel_m | sel_s;
  assign capture = (state_q == ST_RUN) & key_mode;

  // Edit registers; key_mode masks inc/dec in the same cycle.
  field_wrap_cnt #(.MAX(HOUR_MAX)) u_hour (
    .clk(clk), .rst(rst), .load(capture), .load_val(cur_hour),
    .inc(sel_h & key_inc & ~key_mode), .dec(sel_h & key_dec & ~key_mode),
    .val(edit_h)
  );

  field_wrap_cnt #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .load(capture), .load_val(cur_min),
    .inc(sel_m & key_inc & ~key_mode), .dec(sel_m & key_dec & ~key_mode),
    .val(edit_m)
  );

  field_wrap_cnt #(.MAX(MIN_MAX)) u_sec (
    .clk(clk), .rst(rst), .load(capture), .load_val(cur_sec),
    .inc(sel_s & key_inc & ~key_mode), .dec(sel_s & key_dec & ~key_mode),
    .val(edit_s)
  );

  // Next-state, timeout, blink and load logic.
  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    load_en_d  = 1'b0;
    load_day_d = load_day_q;
    blink_rst  = 1'b0;
    if (blink_cnt_q == BLINK_W'(BLINK_CYC - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      phase_d     = phase_q;
    end

    case (state_q)
      ST_RUN: begin
        to_cnt_d = '0;
        if (key_mode) begin
          state_d   = ST_SET_H;
          blink_rst = 1'b1;
        end
      end
      ST_SET_H, ST_SET_M, ST_SET_S: begin
        if (key_mode) begin
          to_cnt_d = '0;
          if (sel_h) begin
            state_d   = ST_SET_M;
            blink_rst = 1'b1;
          end else if (sel_m) begin
            state_d   = ST_SET_S;
            blink_rst = 1'b1;
          end else begin
            state_d = ST_COMMIT;
          end
        end else if (key_inc || key_dec) begin
          // Any edit key restarts the timeout and shows the field solid.
          to_cnt_d  = '0;
          blink_rst = 1'b1;
        end else if (tick_1s) begin
          if (to_cnt_q == TO_W'(TIMEOUT_S - 1)) begin
            state_d  = ST_RUN;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      ST_COMMIT: begin
        state_d    = ST_RUN;
        to_cnt_d   = '0;
        load_en_d  = 1'b1;
        load_day_d = DAY_W'(edit_h) * DAY_W'(SEC_PER_HOUR)
                   + DAY_W'(edit_m) * DAY_W'(SEC_PER_MIN)
                   + DAY_W'(edit_s);
      end
      default: begin
        state_d  = ST_RUN;
        to_cnt_d = '0;
      end
    endcase

    if (blink_rst) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      to_cnt_q    <= '0;
      load_en_q   <= 1'b0;
      load_day_q  <= '0;
    end else begin
      state_q     <= state_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      to_cnt_q    <= to_cnt_d;
      load_en_q   <= load_en_d;
      load_day_q  <= load_day_d;
    end
  end

  // Display path is a pure mux of registered state; live time only in RUN.
  assign disp_hour  = (state_q == ST_RUN) ? cur_hour : edit_h;
  assign disp_min   = (state_q == ST_RUN) ? cur_min  : edit_m;
  assign disp_sec   = (state_q == ST_RUN) ? cur_sec  : edit_s;
  assign blink_mask = {sel_h & phase_q, sel_m & phase_q, sel_s & phase_q};
  assign setting    = in_set | (state_q == ST_COMMIT);
  assign load_en    = load_en_q;
  assign load_day   = load_day_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Testbench for clock_set_ctrl: directed scenarios followed by random key,
// tick and reset traffic, compared every cycle against a mode/field model.
module tb_clock_set_ctrl;

  localparam int unsigned BLINK = 4;
  localparam int unsigned TOUT  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_1s = 1'b0;
  logic        key_mode = 1'b0, key_inc = 1'b0, key_dec = 1'b0;
  logic [4:0]  cur_hour = '0;
  logic [5:0]  cur_min = '0, cur_sec = '0;
  logic [4:0]  disp_hour;
  logic [5:0]  disp_min, disp_sec;
  logic [2:0]  blink_mask;
  logic        load_en;
  logic [16:0] load_day;
  logic        setting;

  clock_set_ctrl #(.BLINK_CYC(BLINK), .TIMEOUT_S(TOUT)) dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s),
    .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .disp_hour(disp_hour), .disp_min(disp_min), .disp_sec(disp_sec),
    .blink_mask(blink_mask), .load_en(load_en), .load_day(load_day),
    .setting(setting)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: mode 0=run,1=hour,2=min,3=sec,4=commit.
  int m_mode = 0;
  int m_h = 0, m_m = 0, m_s = 0;
  int m_to = 0;
  int m_since = 0;
  int m_len = 0;
  int m_day = 0;
  int ch = 0, cm = 0, cs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic int wrap(input int v, input int modn);
    return ((v % modn) + modn) % modn;
  endfunction

  task automatic model_step(input bit r, input bit md, input bit ki, input bit kd, input bit tk);
    m_len = 0;
    if (r) begin
      m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_to = 0; m_since = 0; m_day = 0;
      return;
    end
    case (m_mode)
      0: begin
        m_since++;
        if (md) begin
          m_mode = 1; m_h = ch; m_m = cm; m_s = cs; m_to = 0; m_since = 0;
        end
      end
      1, 2, 3: begin
        if (md) begin
          m_mode++; m_to = 0; m_since = 0;
        end else if (ki || kd) begin
          int d;
          d = (ki && !kd) ? 1 : ((kd && !ki) ? -1 : 0);
          if (m_mode == 1) m_h = wrap(m_h + d, 24);
          if (m_mode == 2) m_m = wrap(m_m + d, 60);
          if (m_mode == 3) m_s = wrap(m_s + d, 60);
          m_to = 0; m_since = 0;
        end else begin
          m_since++;
          if (tk) begin
            m_to++;
            if (m_to == TOUT) begin
              m_mode = 0; m_to = 0;
            end
          end
        end
      end
      default: begin
        m_len = 1;
        m_day = m_h * 3600 + m_m * 60 + m_s;
        m_mode = 0;
      end
    endcase
  endtask

  task automatic check_all();
    int phase;
    logic [2:0] mask;
    phase = (m_since / BLINK) % 2;
    mask = 3'b000;
    if (m_mode >= 1 && m_mode <= 3 && phase == 1) mask[3 - m_mode] = 1'b1;
    chk("setting", 32'(setting), 32'(m_mode != 0));
    chk("disp_hour", 32'(disp_hour), 32'((m_mode == 0) ? ch : m_h));
    chk("disp_min", 32'(disp_min), 32'((m_mode == 0) ? cm : m_m));
    chk("disp_sec", 32'(disp_sec), 32'((m_mode == 0) ? cs : m_s));
    chk("blink_mask", 32'(blink_mask), 32'(mask));
    chk("load_en", 32'(load_en), 32'(m_len));
    chk("load_day", 32'(load_day), 32'(m_day));
  endtask

  // One clock: drive inputs, advance DUT and model, compare.
  task automatic cyc(input bit r, input bit md, input bit ki, input bit kd, input bit tk);
    rst = r; key_mode = md; key_inc = ki; key_dec = kd; tick_1s = tk;
    cur_hour = 5'(ch); cur_min = 6'(cm); cur_sec = 6'(cs);
    @(posedge clk);
    #1;
    model_step(r, md, ki, kd, tk);
    rst = 1'b0; key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0; tick_1s = 1'b0;
    check_all();
  endtask

  task automatic set_cur(input int h, input int mi, input int s);
    ch = h; cm = mi; cs = s;
  endtask

  initial begin
    // Power-on reset
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    chk("reset_setting", 32'(setting), 32'd0);
    chk("reset_mask", 32'(blink_mask), 32'd0);

    // 12:34:56 -> hour +3, minute -35 (wraps) -> 15:59:56
    set_cur(12, 34, 56);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 35; i++) cyc(0, 0, 0, 1, 0);
    chk("min_after_dec35", 32'(disp_min), 32'd59);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("commit_no_load_yet", 32'(load_en), 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("load_pulse", 32'(load_en), 32'd1);
    chk("load_day_57596", 32'(load_day), 32'd57596);
    cyc(0, 0, 0, 0, 0);
    chk("load_pulse_single", 32'(load_en), 32'd0);

    // Hour and minute wrap, commit 23:59:59
    set_cur(23, 0, 59);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("hour_wrap_up", 32'(disp_hour), 32'd0);
    cyc(0, 0, 0, 1, 0);
    chk("hour_wrap_down", 32'(disp_hour), 32'd23);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("min_wrap_down", 32'(disp_min), 32'd59);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("load_day_max", 32'(load_day), 32'd86399);

    // Simultaneous keys
    set_cur(7, 8, 9);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    chk("inc_dec_hold", 32'(disp_hour), 32'd7);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    chk("mode_inc_commit", 32'(setting), 32'd1);
    chk("mode_inc_sec_kept", 32'(disp_sec), 32'd9);
    cyc(0, 0, 0, 0, 0);
    chk("mode_inc_load", 32'(load_day), 32'd25689);

    // Timeout abort after the 10th tick, no load
    set_cur(1, 2, 3);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
    end
    chk("timeout_run", 32'(setting), 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);

    // Key together with the 9th tick keeps editing
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1);
    chk("timeout_key_rescue", 32'(setting), 32'd1);
    cyc(0, 0, 0, 0, 1);
    chk("timeout_second", 32'(setting), 32'd0);

    // Blink in SET_M, solid after inc
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("blink_solid_after_inc", 32'(blink_mask), 32'd0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    chk("blink_min_on", 32'(blink_mask), 32'b010);

    // Reset mid-edit
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    chk("rst_mid_setting", 32'(setting), 32'd0);
    chk("rst_mid_disp", 32'(disp_min), 32'(cm));

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
              int'($urandom_range(0, 59)));
      cyc(($urandom_range(0, 499) == 0),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
